// File: rtl/seq_scan_pkg.sv
// ---------------------------------------------------------------------------
// seq_scan_pkg
// Shared definitions for the serial pattern-scan scheduler:
//   - state_e   : scheduler state encoding (IDLE/LOAD/SHIFT/REPORT)
//   - id_w()    : width of a requester index for N requesters
//   - cnt_w()   : width able to hold a count of 0..W (hit count, bit count)
// ---------------------------------------------------------------------------
package seq_scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      LOAD   = 2'b01,
      SHIFT  = 2'b10,
      REPORT = 2'b11
   } state_e;

   // Never narrower than one bit, so N=1 corner cases still elaborate.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_scan_sched_if.sv
// ---------------------------------------------------------------------------
// seq_scan_sched_if
// Request/result bundle between frame producers and seq_scan_sched.
//   req     [N]      per-requester level request
//   data    [N*W]    frame of requester i at [i*W +: W]
//   gnt     [N]      one-hot capture pulse
//   busy             scheduler not idle
//   done             one-cycle result-valid pulse
//   done_id [ID_W]   requester of the completed frame
//   hit_cnt [CNT_W]  pattern hits in the completed frame
// master = producer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface seq_scan_sched_if
   import seq_scan_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int ID_W  = id_w(N);
   localparam int CNT_W = cnt_w(W);

   logic [N-1:0]     req;
   logic [N*W-1:0]   data;
   logic [N-1:0]     gnt;
   logic             busy;
   logic             done;
   logic [ID_W-1:0]  done_id;
   logic [CNT_W-1:0] hit_cnt;

   modport master (
      output req, data,
      input  gnt, busy, done, done_id, hit_cnt
   );

   modport slave (
      input  req, data,
      output gnt, busy, done, done_id, hit_cnt
   );

endinterface

// File: rtl/seq_det_core.sv
// ---------------------------------------------------------------------------
// seq_det_core
// Serial pattern detector: a PAT_LEN-bit history shift register plus a fill
// counter so that a hit is only reported once PAT_LEN bits of the current
// frame have been seen.
//   clk, rst  clock, asynchronous active-low reset
//   clr       start of frame: empties history and fill count (wins over bit_vld)
//   bit_vld   bit_in is valid this cycle and is shifted in
//   bit_in    serial data, oldest bit first
//   hit       combinational: post-shift history equals PATTERN with a full window
// ---------------------------------------------------------------------------
module seq_det_core #(
   parameter int                 PAT_LEN = 3,
   parameter logic [PAT_LEN-1:0] PATTERN = 3'b101
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic bit_vld,
   input  logic bit_in,
   output logic hit
);
   localparam int FILL_W = $clog2(PAT_LEN + 1);

   logic [PAT_LEN-1:0] hist_q, hist_d, hist_sh;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic               win_full;

   always_comb begin
      // Oldest bit ends up in the MSB, matching PATTERN's orientation.
      hist_sh  = (hist_q << 1) | PAT_LEN'(bit_in);
      // Window is full after this shift if PAT_LEN-1 bits were already held.
      win_full = (fill_q >= FILL_W'(PAT_LEN - 1));
      hit      = bit_vld && !clr && win_full && (hist_sh == PATTERN);

      hist_d = hist_q;
      fill_d = fill_q;
      if (clr) begin
         hist_d = '0;
         fill_d = '0;
      end else if (bit_vld) begin
         hist_d = hist_sh;
         if (fill_q != FILL_W'(PAT_LEN))
            fill_d = fill_q + FILL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_scan_sched.sv
// ---------------------------------------------------------------------------
// seq_scan_sched
// Shares one serial pattern detector among N requesters. A round-robin
// arbiter picks a requester in IDLE, its frame is shifted MSB-first through
// seq_det_core one bit per clock, and the hit count is reported with the
// requester ID. One frame takes W+3 cycles (IDLE, LOAD, W x SHIFT, REPORT).
//   clk   clock, rising edge
//   rst   asynchronous active-low reset (aborts any frame in flight)
//   bus   seq_scan_sched_if.slave: req/data in; gnt/busy/done/done_id/hit_cnt
//         out, all registered
// ---------------------------------------------------------------------------
module seq_scan_sched
   import seq_scan_pkg::*;
#(
   parameter int                 N       = 4,
   parameter int                 W       = 8,
   parameter int                 PAT_LEN = 3,
   parameter logic [PAT_LEN-1:0] PATTERN = 3'b101
) (
   input  logic            clk,
   input  logic            rst,
   seq_scan_sched_if.slave bus
);
   localparam int ID_W  = id_w(N);
   localparam int CNT_W = cnt_w(W);
   localparam int BIT_W = cnt_w(W);

   state_e           state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  win_q, win_d;
   logic [W-1:0]     shreg_q, shreg_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [ID_W-1:0]  done_id_q, done_id_d;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

   logic             arb_found;
   logic [ID_W-1:0]  arb_id;
   logic             det_clr, det_vld, det_hit;

   // Round-robin: first set req bit searching upward from ptr+1 with wrap,
   // so the last winner has the lowest priority.
   always_comb begin
      arb_found = 1'b0;
      arb_id    = '0;
      for (int k = 1; k <= N; k++) begin
         if (!arb_found && bus.req[(int'(ptr_q) + k) % N]) begin
            arb_found = 1'b1;
            arb_id    = ID_W'((int'(ptr_q) + k) % N);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      win_d     = win_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      cnt_d     = cnt_q;
      gnt_d     = '0;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      hit_cnt_d = hit_cnt_q;
      det_clr   = 1'b0;
      det_vld   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (arb_found) begin
               // Frame is taken on the arbitration edge, so anything the
               // producer does after seeing gnt cannot corrupt it.
               win_d   = arb_id;
               shreg_d = bus.data[int'(arb_id)*W +: W];
               gnt_d   = N'(1) << arb_id;
               state_d = LOAD;
            end
         end
         LOAD: begin
            det_clr   = 1'b1;
            cnt_d     = '0;
            bit_cnt_d = '0;
            ptr_d     = win_q;
            state_d   = SHIFT;
         end
         SHIFT: begin
            det_vld   = 1'b1;
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            cnt_d     = cnt_q + CNT_W'(det_hit);
            if (bit_cnt_q == BIT_W'(W - 1)) begin
               // Result registers load here so they are valid in REPORT.
               state_d   = REPORT;
               done_d    = 1'b1;
               done_id_d = win_q;
               hit_cnt_d = cnt_d;
            end
         end
         REPORT: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         ptr_q     <= ID_W'(N - 1);
         win_q     <= '0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         hit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         win_q     <= win_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         hit_cnt_q <= hit_cnt_d;
      end
   end

   seq_det_core #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) u_det (
      .clk     (clk),
      .rst     (rst),
      .clr     (det_clr),
      .bit_vld (det_vld),
      .bit_in  (shreg_q[W-1]),
      .hit     (det_hit)
   );

   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_seq_scan_sched.sv
// ---------------------------------------------------------------------------
// tb_seq_scan_sched
// Self-checking bench for seq_scan_sched: directed frames, round-robin order,
// fairness, mid-frame reset, then randomized requests. A transaction-level
// reference model (cycle offsets since arbitration, windowed hit count over
// the frame's bits) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_seq_scan_sched;
   import seq_scan_pkg::*;

   localparam int                 N       = 4;
   localparam int                 W       = 8;
   localparam int                 PAT_LEN = 3;
   localparam logic [PAT_LEN-1:0] PATTERN = 3'b101;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seq_scan_sched_if #(.N(N), .W(W)) bus ();

   seq_scan_sched #(
      .N       (N),
      .W       (W),
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   int           m_t    = 0;     // cycles since arbitration, 0 = idle
   int           m_ptr  = N - 1;
   int           m_win  = 0;
   int           m_id   = 0;
   int           m_hits = 0;
   logic [W-1:0] m_frame = '0;
   logic [N-1:0] m_gnt  = '0;
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic         auto_drop = 1'b1;

   // Count windows of PAT_LEN consecutive frame bits (MSB sent first) equal
   // to PATTERN, oldest bit in the window's MSB.
   function automatic int ref_hits(input logic [W-1:0] f);
      int n;
      int v;
      n = 0;
      for (int e = PAT_LEN - 1; e < W; e++) begin
         v = 0;
         for (int j = e - PAT_LEN + 1; j <= e; j++)
            v = (v << 1) | int'(f[W-1-j]);
         if (v == int'(PATTERN)) n++;
      end
      return n;
   endfunction

   function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
      for (int k = 1; k <= N; k++)
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_t = 0; m_ptr = N - 1; m_id = 0; m_hits = 0;
      m_gnt = '0; m_busy = 1'b0; m_done = 1'b0;
   endtask

   task automatic step();
      logic [N-1:0]   req_s;
      logic [N*W-1:0] data_s;
      logic           rst_s;
      int             w;
      req_s  = bus.req;
      data_s = bus.data;
      rst_s  = rst;
      @(posedge clk);
      #1;
      cyc++;
      m_gnt  = '0;
      m_done = 1'b0;
      if (!rst_s) begin
         model_reset();
      end else if (m_t == 0) begin
         w = rr_pick(m_ptr, req_s);
         if (w >= 0) begin
            m_win    = w;
            m_ptr    = w;
            m_frame  = data_s[w*W +: W];
            m_gnt[w] = 1'b1;
            m_t      = 1;
         end
      end else if (m_t < W + 2) begin
         m_t++;
         if (m_t == W + 2) begin
            m_done = 1'b1;
            m_id   = m_win;
            m_hits = ref_hits(m_frame);
         end
      end else begin
         m_t = 0;
      end
      m_busy = (m_t != 0);
      check("gnt",     32'(bus.gnt),     32'(m_gnt));
      check("busy",    32'(bus.busy),    32'(m_busy));
      check("done",    32'(bus.done),    32'(m_done));
      check("done_id", 32'(bus.done_id), 32'(m_id));
      check("hit_cnt", 32'(bus.hit_cnt), 32'(m_hits));
      if (auto_drop) bus.req = bus.req & ~m_gnt;
   endtask

   task automatic wait_gnt(output int id, output int c);
      id = -1;
      c  = -1;
      for (int i = 0; i < 40 && id < 0; i++) begin
         step();
         for (int k = 0; k < N; k++)
            if (bus.gnt[k]) begin id = k; c = cyc; end
      end
      if (id < 0) check("gnt_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(output int c);
      c = -1;
      for (int i = 0; i < 40 && c < 0; i++) begin
         step();
         if (bus.done) c = cyc;
      end
      if (c < 0) check("done_timeout", 32'd0, 32'd1);
   endtask

   // One frame from one requester with a hand-computed hit count; also
   // checks request-to-grant and request-to-done latency.
   task automatic run_frame(input int id, input logic [W-1:0] f, input int exp_hits);
      int c0, g, gc, dc;
      bus.data[id*W +: W] = f;
      bus.req[id] = 1'b1;
      c0 = cyc;
      wait_gnt(g, gc);
      check("grant_id", 32'(g), 32'(id));
      check("gnt_lat",  32'(gc - c0), 32'd1);
      wait_done(dc);
      check("done_lat", 32'(dc - c0), 32'(W + 2));
      check("frame_hits", 32'(bus.hit_cnt), 32'(exp_hits));
      check("frame_id",   32'(bus.done_id), 32'(id));
      step();
   endtask

   int g, gc, dc, prev;
   int exp_order [4] = '{0, 1, 2, 3};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req  = '0;
      bus.data = '0;
      #2 rst = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();

      // Directed single frames
      run_frame(0, 8'b10101010, 3);
      run_frame(2, 8'b10110101, 3);
      run_frame(2, 8'b10100000, 1);
      run_frame(2, 8'h00, 0);
      run_frame(2, 8'hFF, 0);
      // Frame isolation: "10" tail + "1" head must not match across frames
      run_frame(2, 8'b00000010, 0);
      run_frame(2, 8'b10000000, 0);
      // Leave ptr at 3 so requester 0 wins next
      run_frame(3, 8'b01011010, 2);

      // Round-robin with all four requesting
      for (int k = 0; k < N; k++) bus.data[k*W +: W] = W'($urandom);
      bus.req = 4'b1111;
      prev = -1;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(g, gc);
         check("rr_order", 32'(g), 32'(exp_order[k]));
         wait_done(dc);
         if (prev >= 0) check("done_spacing", 32'(dc - prev), 32'(W + 3));
         prev = dc;
      end
      step();
      bus.req = 4'b0101;
      wait_gnt(g, gc);
      check("rr_0101_first", 32'(g), 32'd0);
      wait_done(dc);
      wait_gnt(g, gc);
      check("rr_0101_second", 32'(g), 32'd2);
      wait_done(dc);
      step();

      // Fairness: 1 re-requests right after its done while 3 waits
      bus.req = 4'b0010;
      wait_gnt(g, gc);
      check("fair_first", 32'(g), 32'd1);
      bus.req[3] = 1'b1;
      wait_done(dc);
      bus.req[1] = 1'b1;
      wait_gnt(g, gc);
      check("fair_3_before_1", 32'(g), 32'd3);
      wait_done(dc);
      wait_gnt(g, gc);
      check("fair_then_1", 32'(g), 32'd1);
      wait_done(dc);
      step();

      // Mid-frame reset during SHIFT
      bus.data[2*W +: W] = 8'b10101010;
      bus.req = 4'b0100;
      wait_gnt(g, gc);
      check("pre_rst_gnt", 32'(g), 32'd2);
      repeat (5) step();
      rst = 1'b0;
      bus.req = '0;
      #1;
      check("rst_gnt",     32'(bus.gnt),     32'd0);
      check("rst_busy",    32'(bus.busy),    32'd0);
      check("rst_done",    32'(bus.done),    32'd0);
      check("rst_done_id", 32'(bus.done_id), 32'd0);
      check("rst_hit_cnt", 32'(bus.hit_cnt), 32'd0);
      model_reset();
      repeat (3) step();
      rst = 1'b1;
      step();
      run_frame(1, 8'b10101101, 3);

      // Randomized requests
      for (int i = 0; i < 800; i++) begin
         for (int k = 0; k < N; k++) begin
            if (!bus.req[k] && $urandom_range(0, 7) == 0) begin
               bus.data[k*W +: W] = W'($urandom);
               bus.req[k] = 1'b1;
            end else if (bus.req[k] && $urandom_range(0, 63) == 0) begin
               bus.req[k] = 1'b0;
            end else if ($urandom_range(0, 31) == 0) begin
               bus.data[k*W +: W] = W'($urandom);
            end
         end
         step();
      end
      bus.req = '0;
      repeat (15) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
